// File: rtl/ps2_pkg.sv
// ps2_pkg: scan codes, prefixes, receiver states and timeout default shared by the PS/2 key decoder.
package ps2_pkg;
  localparam int TIMEOUT_DEFAULT = 65000;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] PFX_EXT  = 8'hE0;
  localparam logic [7:0] PFX_BRK  = 8'hF0;
  typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
endpackage

// File: rtl/ps2_rx.sv
// ps2_rx: synchronizes the PS/2 pins and receives 11-bit frames into bytes with parity, stop and timeout checks.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [1:0] clk_sync, dat_sync;
  logic clk_q, fall, dat, parity, timeout, stop_ok;
  logic [2:0] bit_cnt;
  logic [CW-1:0] tmo;
  rx_state_t state, state_n;
  assign dat = dat_sync[1];
  assign fall = clk_q & ~clk_sync[1];
  assign timeout = state != RX_IDLE && !fall && tmo == CW'(TIMEOUT_CYCLES);
  // Odd parity: data bits plus parity bit must XOR to 1.
  assign stop_ok = dat & (^{rx_byte, parity});
  always_ff @(posedge clk)
    state <= rst ? RX_IDLE : state_n;
  always_comb begin
    state_n = state;
    if (timeout)
      state_n = RX_IDLE;
    else if (fall)
      case (state)
        RX_IDLE:   state_n = dat ? RX_IDLE : RX_DATA;
        RX_DATA:   state_n = bit_cnt == 3'd7 ? RX_PARITY : RX_DATA;
        RX_PARITY: state_n = RX_STOP;
        default:   state_n = RX_IDLE;
      endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync   <= 2'b11;
      dat_sync   <= 2'b11;
      clk_q      <= 1'b1;
      bit_cnt    <= '0;
      parity     <= 1'b0;
      rx_byte    <= '0;
      tmo        <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      clk_sync   <= {clk_sync[0], ps2_clk};
      dat_sync   <= {dat_sync[0], ps2_data};
      clk_q      <= clk_sync[1];
      byte_valid <= fall && state == RX_STOP && stop_ok;
      frame_err  <= timeout || (fall && state == RX_STOP && !stop_ok);
      tmo        <= (fall || state == RX_IDLE) ? '0 : tmo + CW'(1);
      if (fall && state == RX_IDLE) bit_cnt <= '0;
      if (fall && state == RX_DATA) begin
        rx_byte <= {dat, rx_byte[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (fall && state == RX_PARITY) parity <= dat;
    end
  end
endmodule

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: turns PS/2 make/break sequences into held-key levels for two players.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic key_w,
  output logic key_a,
  output logic key_d,
  output logic key_up,
  output logic key_left,
  output logic key_right,
  output logic frame_err
);
  logic [7:0] rx_byte;
  logic byte_valid, ext, brk, is_pfx;
  logic [5:0] keys, hit;
  ps2_rx #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
    .clk(clk),
    .rst(rst),
    .ps2_clk(ps2_clk),
    .ps2_data(ps2_data),
    .rx_byte(rx_byte),
    .byte_valid(byte_valid),
    .frame_err(frame_err)
  );
  assign is_pfx = rx_byte == PFX_EXT || rx_byte == PFX_BRK;
  always_comb
    hit = byte_valid && !is_pfx ? {!ext && rx_byte == SC_W, !ext && rx_byte == SC_A,
                                   !ext && rx_byte == SC_D, ext && rx_byte == SC_UP,
                                   ext && rx_byte == SC_LEFT, ext && rx_byte == SC_RIGHT} : '0;
  // Prefixes accumulate in either order; any other byte consumes both flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      keys <= '0;
      ext  <= 1'b0;
      brk  <= 1'b0;
    end else if (byte_valid) begin
      ext  <= rx_byte == PFX_EXT || (ext && rx_byte == PFX_BRK);
      brk  <= rx_byte == PFX_BRK || (brk && rx_byte == PFX_EXT);
      keys <= (keys & ~hit) | (hit & {6{!brk}});
    end
  end
  assign {key_w, key_a, key_d, key_up, key_left, key_right} = keys;
endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder: table vectors, corner sequences and random frames against a scan-code reference model.
module tb_ps2_key_decoder;
  localparam int TMO = 200;
  logic clk = 0, rst = 1, ps2_clk = 1, ps2_data = 1;
  logic key_w, key_a, key_d, key_up, key_left, key_right, frame_err;
  int total = 0, bad = 0, err_cnt = 0, width_bad = 0;
  logic err_prev = 0;
  logic [5:0] k3, k4, prev, m_keys;
  bit m_ext, m_brk;
  int idx[int];
  typedef struct {
    logic [7:0] code;
    bit         bad;
    logic [5:0] keys;
    int         err;
  } vec_t;
  vec_t vecs[$];

  ps2_key_decoder #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .key_w(key_w), .key_a(key_a), .key_d(key_d), .key_up(key_up),
    .key_left(key_left), .key_right(key_right), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_err) begin
      err_cnt++;
      if (err_prev) width_bad++;
    end
    err_prev = frame_err;
  end

  function automatic logic [5:0] keys();
    return {key_w, key_a, key_d, key_up, key_left, key_right};
  endfunction

  function automatic logic [10:0] frame(input logic [7:0] b, input bit corrupt);
    return {1'b1, (~^b) ^ corrupt, b, 1'b0};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, exp);
    end
  endtask

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = f[i];
      tick(5);
      ps2_clk = 0;
      if (i == 10) begin
        tick(3);
        k3 = keys();
        tick(1);
        k4 = keys();
        tick(6);
      end else tick(10);
      ps2_clk = 1;
      tick(5);
    end
    ps2_data = 1;
  endtask

  task automatic do_reset(input int n);
    rst = 1;
    tick(n);
    rst = 0;
  endtask

  task automatic model(input logic [7:0] b);
    if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else begin
      if (idx.exists({m_ext ? 256 : 0} + int'(b))) m_keys[idx[(m_ext ? 256 : 0) + int'(b)]] = !m_brk;
      m_ext = 0;
      m_brk = 0;
    end
  endtask

  initial begin
    logic [7:0] pool[13];
    logic [7:0] code;
    bit corrupt;
    int e0;
    idx[8'h1D] = 5; idx[8'h1C] = 4; idx[8'h23] = 3;
    idx[256 + 8'h75] = 2; idx[256 + 8'h6B] = 1; idx[256 + 8'h74] = 0;
    pool = '{8'h1D, 8'h1C, 8'h23, 8'h75, 8'h6B, 8'h74, 8'hE0, 8'hF0, 8'hE0, 8'hF0, 8'hE1, 8'hAA, 8'h00};
    vecs.push_back('{8'h1D, 0, 6'b100000, 0});
    vecs.push_back('{8'hF0, 0, 6'b100000, 0});
    vecs.push_back('{8'h1D, 0, 6'b000000, 0});
    vecs.push_back('{8'hE0, 0, 6'b000000, 0});
    vecs.push_back('{8'h6B, 0, 6'b000010, 0});
    vecs.push_back('{8'hE0, 0, 6'b000010, 0});
    vecs.push_back('{8'hF0, 0, 6'b000010, 0});
    vecs.push_back('{8'h6B, 0, 6'b000000, 0});
    vecs.push_back('{8'hE0, 0, 6'b000000, 0});
    vecs.push_back('{8'h1D, 0, 6'b000000, 0});
    vecs.push_back('{8'h1C, 1, 6'b000000, 1});
    vecs.push_back('{8'h1C, 0, 6'b010000, 0});
    vecs.push_back('{8'h75, 0, 6'b010000, 0});
    vecs.push_back('{8'hE0, 0, 6'b010000, 0});
    vecs.push_back('{8'h75, 0, 6'b010100, 0});
    vecs.push_back('{8'hE0, 0, 6'b010100, 0});
    vecs.push_back('{8'h74, 0, 6'b010101, 0});
    vecs.push_back('{8'hE1, 0, 6'b010101, 0});
    vecs.push_back('{8'hAA, 0, 6'b010101, 0});
    vecs.push_back('{8'hFA, 0, 6'b010101, 0});
    vecs.push_back('{8'hEE, 0, 6'b010101, 0});
    vecs.push_back('{8'h23, 0, 6'b011101, 0});
    vecs.push_back('{8'h1D, 0, 6'b111101, 0});
    vecs.push_back('{8'h23, 0, 6'b111101, 0});
    vecs.push_back('{8'h1D, 0, 6'b111101, 0});
    vecs.push_back('{8'hF0, 0, 6'b111101, 0});
    vecs.push_back('{8'h1D, 0, 6'b011101, 0});
    vecs.push_back('{8'hF0, 0, 6'b011101, 0});
    vecs.push_back('{8'h1C, 0, 6'b001101, 0});
    vecs.push_back('{8'hE0, 0, 6'b001101, 0});
    vecs.push_back('{8'hF0, 0, 6'b001101, 0});
    vecs.push_back('{8'h75, 0, 6'b001001, 0});
    vecs.push_back('{8'hF0, 0, 6'b001001, 0});
    vecs.push_back('{8'hE0, 0, 6'b001001, 0});
    vecs.push_back('{8'h74, 0, 6'b001000, 0});
    vecs.push_back('{8'hF0, 0, 6'b001000, 0});
    vecs.push_back('{8'h23, 0, 6'b000000, 0});

    do_reset(3);
    tick(1);
    chk("reset_keys", keys(), 0);
    chk("reset_err", frame_err, 0);

    prev = 0;
    foreach (vecs[i]) begin
      e0 = err_cnt;
      send_bits(frame(vecs[i].code, vecs[i].bad), 11);
      tick(2);
      chk($sformatf("vec%0d_pre", i), k3, prev);
      chk($sformatf("vec%0d_keys", i), k4, vecs[i].keys);
      chk($sformatf("vec%0d_err", i), err_cnt - e0, vecs[i].err);
      prev = vecs[i].keys;
    end

    e0 = err_cnt;
    send_bits(frame(8'h23, 0), 5);
    tick(TMO + 10);
    chk("timeout_err", err_cnt - e0, 1);
    chk("timeout_keys", keys(), 0);
    e0 = err_cnt;
    send_bits(frame(8'h23, 0), 11);
    tick(2);
    chk("after_timeout_keys", keys(), 6'b001000);
    chk("after_timeout_err", err_cnt - e0, 0);

    send_bits(frame(8'h1C, 0), 11);
    send_bits(frame(8'hF0, 0), 11);
    rst = 1;
    tick(1);
    rst = 0;
    chk("rst_keys", keys(), 0);
    chk("rst_err", frame_err, 0);
    send_bits(frame(8'h1C, 0), 11);
    tick(2);
    chk("rst_brk_cleared", keys(), 6'b010000);

    send_bits(frame(8'h1D, 0), 4);
    do_reset(2);
    tick(20);
    chk("midframe_rst_keys", keys(), 0);
    e0 = err_cnt;
    send_bits(frame(8'h1D, 0), 11);
    tick(2);
    chk("midframe_rst_next", keys(), 6'b100000);
    chk("midframe_rst_err", err_cnt - e0, 0);

    do_reset(2);
    m_keys = 0;
    m_ext = 0;
    m_brk = 0;
    for (int i = 0; i < 70; i++) begin
      code = pool[$urandom_range(0, 12)];
      if (code == 8'h00) code = 8'($urandom_range(0, 255));
      corrupt = $urandom_range(0, 7) == 0;
      e0 = err_cnt;
      send_bits(frame(code, corrupt), 11);
      tick(2);
      if (!corrupt) model(code);
      chk($sformatf("rnd%0d_keys(%02h)", i, code), keys(), m_keys);
      chk($sformatf("rnd%0d_err", i), err_cnt - e0, corrupt ? 1 : 0);
    end

    chk("err_pulse_width", width_bad, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ps2_key_decoder.md
PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 65000, number of clk cycles without a ps2_clk falling edge before a partial frame is abandoned.
REQ-002 clk  input  1  system clock; all logic is on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 ps2_clk  input  1  raw keyboard clock, asynchronous to clk.
REQ-005 ps2_data  input  1  raw keyboard data, asynchronous to clk.
REQ-006 key_w / key_a / key_d  output  1 each  player-1 held-key levels for scan codes 0x1D / 0x1C / 0x23.
REQ-007 key_up / key_left / key_right  output  1 each  player-2 held-key levels for extended codes E0 75 / E0 6B / E0 74.
REQ-008 frame_err  output  1  one-cycle pulse on every discarded frame.

Function
REQ-009 ps2_clk and ps2_data SHALL each pass through a 2-FF synchronizer; a falling-edge strobe SHALL be a registered compare of the synchronized ps2_clk; no other logic touches the raw pins.
REQ-010 The receiver FSM SHALL have states IDLE, DATA, PARITY, STOP and SHALL sample synchronized ps2_data only on the falling-edge strobe.
REQ-011 IDLE: data=0 at the strobe -> DATA, bit counter cleared; data=1 -> stay IDLE, no error.
REQ-012 DATA: bits SHALL shift in LSB first; after the 8th bit -> PARITY.
REQ-013 PARITY: the sampled bit SHALL be stored; -> STOP.
REQ-014 STOP: parity SHALL be odd over 8 data bits plus parity bit, and stop bit SHALL be 1; if both hold, pulse internal byte_valid for exactly 1 cycle, 1 cycle after the stop strobe; otherwise pulse frame_err for 1 cycle; in both cases -> IDLE.
REQ-015 Timeout counter SHALL clear on every strobe and count in DATA/PARITY/STOP; on reaching TIMEOUT_CYCLES, discard the frame, pulse frame_err once, and go to IDLE.
REQ-016 Decoder SHALL hold flags ext and brk; byte 0xE0 sets ext; byte 0xF0 sets brk; neither changes key outputs.
REQ-017 Any other byte SHALL be looked up with the current ext flag. On a match, that key output becomes !brk. Whether or not it matches, ext and brk clear.
REQ-018 Key outputs SHALL be registered and SHALL update on the clk edge after byte_valid; overall latency from the stop-bit strobe SHALL be 2 cycles.
REQ-019 Unknown codes SHALL leave all keys unchanged: E0 1D, 0x75 without E0, E1, AA, FA, EE.
REQ-020 Typematic repeat makes SHALL keep the key at 1 without glitching.
REQ-021 Multiple keys SHALL be held independently; a release affects only its own key.
REQ-022 frame_err and byte_valid SHALL never both be 1 in the same cycle.

Reset
REQ-023 rst SHALL force all key outputs to 0, frame_err to 0, the receiver to IDLE, and clear counters, shift register, ext and brk. This applies mid-frame and mid-prefix.
REQ-024 After rst deasserts, a frame already in progress on the pins SHALL NOT be decoded unless its start bit is seen after reset.

Structure
REQ-025 Scan-code and prefix constants SHALL live in shared package ps2_pkg: SC_W, SC_A, SC_D, SC_UP, SC_LEFT, SC_RIGHT, PFX_EXT=E0, PFX_BRK=F0.
REQ-026 Receiver state enum and TIMEOUT default SHALL also live in ps2_pkg.
REQ-027 The frame receiver SHALL be sub-module ps2_rx (sync, edge detect, FSM, timeout; outputs byte, byte_valid, frame_err).
REQ-028 Make/break decode and key registers SHALL be in ps2_key_decoder.
REQ-029 Target size: 120-400 RTL lines total.

Verification
REQ-030 Frame 0x1D -> key_w=1 two cycles after the stop strobe; then F0,1D -> key_w=0; all other keys stay 0 throughout.
REQ-031 E0,6B -> key_left=1 and key_a=0; E0,F0,6B -> key_left=0; E0,1D -> no output change.
REQ-032 0x1C with even parity -> frame_err high exactly 1 cycle and key_a stays 0; next good 0x1C -> key_a=1 with no frame_err.
REQ-033 Start plus 4 data bits, then ps2_clk idle for TIMEOUT_CYCLES+10 -> one frame_err pulse; following full 0x23 frame -> key_d=1.
REQ-034 Sequence 1D, 23, 1D, 23 (repeat), F0,1D -> key_w=0 and key_d=1 at end.
REQ-035 Hold key_a=1, then send F0 and assert rst for 1 cycle, then send 1C -> all outputs 0 after rst, then key_a=1 (break flag cleared by reset).
